// File: rtl/position_counter.sv
// Rate-limited, saturating 10-bit position counter driven by a 2-bit move command.
// Define POSCNT_ACCEL_EN to enable the FAST state (acceleration after ACCEL_STEPS slow steps).
module position_counter #(
    parameter int TICK_DIV    = 250000,
    parameter int LOW_LIMIT   = 15,
    parameter int HIGH_LIMIT  = 624,
    parameter int RESET_VAL   = 320,
    parameter int STEP_FAST   = 4,
    parameter int ACCEL_STEPS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] controlSignal,
    output logic [9:0] cntVal,
    output logic       moving,
    output logic       atLow,
    output logic       atHigh
);

`ifdef POSCNT_ACCEL_EN
    typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;
`else
    typedef enum logic [0:0] {IDLE, SLOW} state_t;
`endif

    localparam logic [19:0] DIV_LAST  = 20'(TICK_DIV - 1);
    localparam logic [10:0] LOW_11    = 11'(LOW_LIMIT);
    localparam logic [10:0] HIGH_11   = 11'(HIGH_LIMIT);
    localparam logic [9:0]  LOW_10    = 10'(LOW_LIMIT);
    localparam logic [9:0]  HIGH_10   = 10'(HIGH_LIMIT);
    localparam logic [9:0]  RESET_10  = 10'(RESET_VAL);
    localparam logic [1:0]  HOLD_CMD  = 2'b10;

    // Elaboration-time sanity checks on the configuration.
    if (TICK_DIV < 2 || TICK_DIV > 1048576) begin : g_bad_tick_div
        $error("position_counter: TICK_DIV out of range");
    end
    if (LOW_LIMIT < 0 || LOW_LIMIT >= HIGH_LIMIT || HIGH_LIMIT > 1023) begin : g_bad_limits
        $error("position_counter: illegal LOW_LIMIT/HIGH_LIMIT");
    end
    if (RESET_VAL < LOW_LIMIT || RESET_VAL > HIGH_LIMIT) begin : g_bad_reset_val
        $error("position_counter: RESET_VAL outside limits");
    end
    if (STEP_FAST < 1 || STEP_FAST > 15 || ACCEL_STEPS < 1 || ACCEL_STEPS > 31) begin : g_bad_accel
        $error("position_counter: illegal STEP_FAST/ACCEL_STEPS");
    end

    state_t      state, state_next;
    logic [1:0]  cmdPrev;
    logic [19:0] divCnt, div_next;
    logic [9:0]  cnt_next;
    logic        active, same_run;
    logic [10:0] step, cnt_ext, sum, diff;

`ifdef POSCNT_ACCEL_EN
    localparam logic [4:0] ACCEL_5 = 5'(ACCEL_STEPS);
    logic [4:0] runCnt, run_next, run_inc;
`endif

    // Next-state, prescaler and saturating position arithmetic.
    always_comb begin
        state_next = state;
        div_next   = divCnt;
        cnt_next   = cntVal;
        active     = ~controlSignal[1];
        same_run   = active && (controlSignal == cmdPrev);
        cnt_ext    = {1'b0, cntVal};
        step       = 11'd1;
        sum        = cnt_ext + step;
        diff       = cnt_ext - step;
`ifdef POSCNT_ACCEL_EN
        run_next   = runCnt;
        run_inc    = runCnt + 5'd1;
        if (state == FAST) begin
            step = 11'(STEP_FAST);
            sum  = cnt_ext + step;
            diff = cnt_ext - step;
        end
`endif
        if (!same_run) begin
            div_next   = 20'd0;
            state_next = active ? SLOW : IDLE;
`ifdef POSCNT_ACCEL_EN
            run_next   = 5'd0;
`endif
        end else if (divCnt == DIV_LAST) begin
            div_next = 20'd0;
            if (controlSignal[0]) begin
                cnt_next = (sum > HIGH_11) ? HIGH_10 : sum[9:0];
            end else begin
                // Compare before subtracting so the 11-bit result never wraps below 0.
                cnt_next = (cnt_ext < LOW_11 + step) ? LOW_10 : diff[9:0];
            end
            if (state == IDLE) begin
                state_next = SLOW;
            end
`ifdef POSCNT_ACCEL_EN
            if (runCnt != ACCEL_5) begin
                run_next = run_inc;
            end
            if (state == SLOW && run_inc == ACCEL_5) begin
                state_next = FAST;
            end
`endif
        end else begin
            div_next = divCnt + 20'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cmdPrev <= HOLD_CMD;
            divCnt  <= 20'd0;
            cntVal  <= RESET_10;
            atLow   <= (RESET_10 == LOW_10);
            atHigh  <= (RESET_10 == HIGH_10);
`ifdef POSCNT_ACCEL_EN
            runCnt  <= 5'd0;
`endif
        end else begin
            state   <= state_next;
            cmdPrev <= controlSignal;
            divCnt  <= div_next;
            cntVal  <= cnt_next;
            atLow   <= (cnt_next == LOW_10);
            atHigh  <= (cnt_next == HIGH_10);
`ifdef POSCNT_ACCEL_EN
            runCnt  <= run_next;
`endif
        end
    end

    assign moving = (state != IDLE);

endmodule

// File: tb/tb_position_counter.sv
// Directed self-checking bench for position_counter; expectations follow the
// POSCNT_ACCEL_EN setting of the build.
module tb_position_counter;

    localparam int TICK_DIV    = 4;
    localparam int LOW_LIMIT   = 15;
    localparam int HIGH_LIMIT  = 624;
    localparam int RESET_VAL   = 320;
    localparam int STEP_FAST   = 4;
    localparam int ACCEL_STEPS = 16;
`ifdef POSCNT_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] controlSignal;
    logic [9:0] cntVal;
    logic       moving, atLow, atHigh;

    int testCount = 0;
    int failCount = 0;
    int expCnt;

    position_counter #(
        .TICK_DIV(TICK_DIV), .LOW_LIMIT(LOW_LIMIT), .HIGH_LIMIT(HIGH_LIMIT),
        .RESET_VAL(RESET_VAL), .STEP_FAST(STEP_FAST), .ACCEL_STEPS(ACCEL_STEPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .controlSignal(controlSignal),
        .cntVal(cntVal), .moving(moving), .atLow(atLow), .atHigh(atHigh)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tickEdge();
        @(posedge clk);
        #1;
    endtask

    // Drives a new command, then follows it for 'edges' clock edges after the
    // first sampling edge, predicting the position with a small tick model.
    task automatic applyStimulus(input logic [1:0] cmd, input int edges);
        bit act;
        int t, stepSize;
        act = ~cmd[1];
        controlSignal = cmd;
        tickEdge();
        checkOutput("first-edge cntVal", 32'(cntVal), 32'(expCnt));
        checkOutput("first-edge moving", 32'(moving), 32'(act));
        for (int k = 1; k <= edges; k++) begin
            tickEdge();
            if (act && (k % TICK_DIV == 0)) begin
                t = k / TICK_DIV;
                stepSize = (ACCEL && t > ACCEL_STEPS) ? STEP_FAST : 1;
                if (cmd[0]) expCnt = (expCnt + stepSize > HIGH_LIMIT) ? HIGH_LIMIT : expCnt + stepSize;
                else        expCnt = (expCnt - stepSize < LOW_LIMIT) ? LOW_LIMIT : expCnt - stepSize;
            end
            checkOutput("cntVal", 32'(cntVal), 32'(expCnt));
            checkOutput("moving", 32'(moving), 32'(act));
            checkOutput("atLow", 32'(atLow), 32'(expCnt == LOW_LIMIT));
            checkOutput("atHigh", 32'(atHigh), 32'(expCnt == HIGH_LIMIT));
        end
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        tickEdge();
        expCnt = RESET_VAL;
        checkOutput("reset cntVal", 32'(cntVal), 32'd320);
        checkOutput("reset moving", 32'(moving), 32'd0);
        checkOutput("reset atLow", 32'(atLow), 32'd0);
        checkOutput("reset atHigh", 32'(atHigh), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        controlSignal = 2'b10;
        resetPulse();

        // Idle hold, then a short increment run: 321..324 every 4 edges.
        applyStimulus(2'b10, 20);
        applyStimulus(2'b01, 16);
        checkOutput("inc16 cntVal", 32'(cntVal), 32'd324);

        // Long run from reset value: 336 after 64 edges, then fast or slow.
        resetPulse();
        applyStimulus(2'b01, 64);
        checkOutput("run64 cntVal", 32'(cntVal), 32'd336);
        applyStimulus(2'b11, 0);
        resetPulse();
        applyStimulus(2'b01, 100);
        checkOutput("run100 cntVal", 32'(cntVal), ACCEL ? 32'd372 : 32'd345);

        // One dec, then climb into the upper limit (clamped) and stay there.
        applyStimulus(2'b00, 4);
        applyStimulus(2'b01, 1200);
        checkOutput("top clamp cntVal", 32'(cntVal), 32'd624);
        checkOutput("top clamp atHigh", 32'(atHigh), 32'd1);

        // Reversal: dec at edge 4, switch at edge 6, inc 4 edges later.
        applyStimulus(2'b00, 5);
        checkOutput("reversal dec", 32'(cntVal), 32'd623);
        applyStimulus(2'b01, 4);
        checkOutput("reversal inc", 32'(cntVal), 32'd624);

        // One-cycle hold glitch restarts the prescaler.
        applyStimulus(2'b00, 6);
        applyStimulus(2'b10, 0);
        applyStimulus(2'b00, 3);
        checkOutput("glitch no early step", 32'(cntVal), 32'd623);
        tickEdge();
        checkOutput("glitch step", 32'(cntVal), 32'd622);
        expCnt = 622;

        // Descend into the lower limit.
        applyStimulus(2'b01, 0);
        applyStimulus(2'b00, 2600);
        checkOutput("bottom clamp cntVal", 32'(cntVal), 32'd15);
        checkOutput("bottom clamp atLow", 32'(atLow), 32'd1);

        // Reset mid-run with the increment command still asserted.
        applyStimulus(2'b01, 10);
        resetPulse();
        applyStimulus(2'b01, 3);
        checkOutput("post-reset no step", 32'(cntVal), 32'd320);
        tickEdge();
        checkOutput("post-reset first inc", 32'(cntVal), 32'd321);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
